mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port round-robin arbiter that shares the single burst memory port (the 32-bit `memory` model / external memory) between two `generic_cache` instances, e.g. instruction cache on port 0 and data cache on port 1. It grants one requester at a time and holds the grant for a complete burst. For a read burst, that means until every `rd_valid` beat has been returned; for a write burst, until every write beat has been accepted. It sits between the caches' `mem_*` master ports and the memory slave port.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, memory beat width
- `BURSTLEN_WIDTH`, 3, burst length field; beats per burst = `burst_len` + 1
- `clock`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `m0_addr`, `m1_addr`  in  ADDR_WIDTH  requester burst start address
- `m0_burst_len`, `m1_burst_len`  in  BURSTLEN_WIDTH  requester beats-1
- `m0_rd`, `m1_rd`  in  1  read burst request
- `m0_wr`, `m1_wr`  in  1  write beat valid
- `m0_wr_data`, `m1_wr_data`  in  DATA_WIDTH  write beat data
- `m0_rd_data`, `m1_rd_data`  out  DATA_WIDTH  read data, both driven from `mem_rd_data`
- `m0_rd_valid`, `m1_rd_valid`  out  1  read beat valid, granted requester only
- `m0_waitrequest`, `m1_waitrequest`  out  1  stall to requester
- `mem_addr`, `mem_burst_len`, `mem_wr_data`  out  widths as above  forwarded from the granted requester
- `mem_rd`, `mem_wr`  out  1  forwarded request strobes
- `mem_rd_data`  in  DATA_WIDTH  memory read data
- `mem_rd_valid`  in  1  memory read beat valid
- `mem_waitrequest`  in  1  memory stall

## Operation
- **States:** IDLE, GRANT, RD_DATA. Registers:
  - `grant` (0/1)
  - `last` (last granted port)
  - `beat_cnt` (BURSTLEN_WIDTH bits)
  - `len_q` (latched `burst_len`)
- **IDLE:**
  - `mem_rd` = `mem_wr` = 0.
  - Both `mX_waitrequest` = 1.
  - A port is requesting when its `rd` or `wr` is high.
  - If one port requests, it wins. If both request, the port ≠ `last` wins.
  - On a win: `grant` ← winner, `last` ← winner, go to GRANT.
- **GRANT:**
  - `mem_addr`, `mem_burst_len`, `mem_wr_data`, `mem_rd` and `mem_wr` are the granted port's inputs.
  - The granted port's `waitrequest` = `mem_waitrequest`. The other port's `waitrequest` = 1.
  - **Read accept** (`mem_rd` & !`mem_waitrequest`): latch `len_q` ← `burst_len`, clear `beat_cnt`, go to RD_DATA.
  - **Write beat accept** (`mem_wr` & !`mem_waitrequest`):
    - On the first beat (`beat_cnt` = 0), latch `len_q` ← `burst_len`.
    - If `beat_cnt` = `burst_len` (first beat) or `beat_cnt` = `len_q` (later beats), go to IDLE and clear `beat_cnt`. Otherwise increment `beat_cnt`.
  - `rd` and `wr` both high on the granted port: `wr` wins and `mem_rd` is forced to 0. This is a protocol violation and is flagged by an assertion.
  - Granted port has `rd` = `wr` = 0 and `beat_cnt` = 0: release, go to IDLE.
- **RD_DATA:**
  - `mem_rd` = `mem_wr` = 0. Both `waitrequest` = 1.
  - The granted port's `rd_valid` = `mem_rd_valid`; the other port's `rd_valid` = 0.
  - Each `mem_rd_valid` increments `beat_cnt`. The beat with `beat_cnt` = `len_q` returns to IDLE and clears `beat_cnt`.
- **Outside RD_DATA:** `mem_rd_valid` is ignored and both `rd_valid` = 0.
- **Reset:**
  - State = IDLE, `grant` = 0, `last` = 1 (so port 0 wins the first tie), `beat_cnt` = 0, `len_q` = 0.
  - Outputs: `mem_rd` = `mem_wr` = 0, both `waitrequest` = 1, both `rd_valid` = 0. `mem_addr`, `mem_burst_len` and `mem_wr_data` follow port 0's inputs.
  - Reset mid-burst abandons the burst. Memory is reset in the same cycle by the system.

## Timing
- **Arbitration:** one cycle. A request seen in IDLE at edge N is forwarded to memory starting cycle N+1.
- **Datapath:** the `mem_*` outputs and `mX_waitrequest` are combinational from state, `grant`, requester inputs and `mem_waitrequest`. There is no registered data path.
- **Read overhead:** +1 cycle vs. direct connection. `rd_valid` has zero added latency.
- **Bus turnaround:** after the last read beat or the last write beat is accepted, at least one IDLE cycle passes before the next grant.
- **Fairness:** under continuous requests from both ports, grants strictly alternate 0,1,0,1.

## Test plan
- **Single read, port 0:** `m0_rd`, addr 0x100, `burst_len` 7 → `mem_rd` high from the cycle after request. After accept, exactly 8 `m0_rd_valid` with data equal to memory words 0x40..0x47. `m1_rd_valid` stays 0.
- **Simultaneous reads after reset:** `m0_rd` and `m1_rd` asserted in the same cycle → port 0 completes its 8 beats first. Port 1 is granted 2 cycles after port 0's last beat. `m1_waitrequest` stays 1 throughout port 0's burst.
- **Write burst under stall:** `m1_wr`, `burst_len` 7, `mem_waitrequest` toggled every other cycle → exactly 8 beats reach memory in order. Grant then returns to IDLE. A concurrent `m0_rd` is granted next.
- **Fairness:** both ports issue back-to-back read bursts for 20 bursts → grant order is 0,1,0,1,… and each port gets 10 grants.
- **Stray and reset:** pulse `mem_rd_valid` in IDLE → no `rd_valid` asserted. Assert `reset` after the 3rd `rd_valid` beat → the next cycle shows IDLE outputs. A fresh port 0 read then completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one burst memory port between two caches.
// A grant is held for a complete read burst (all rd_valid beats) or write burst.
module mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BURSTLEN_WIDTH = 3
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [ADDR_WIDTH-1:0]     m0_addr,
   input  logic [BURSTLEN_WIDTH-1:0] m0_burst_len,
   input  logic                      m0_rd,
   input  logic                      m0_wr,
   input  logic [DATA_WIDTH-1:0]     m0_wr_data,
   output logic [DATA_WIDTH-1:0]     m0_rd_data,
   output logic                      m0_rd_valid,
   output logic                      m0_waitrequest,
   input  logic [ADDR_WIDTH-1:0]     m1_addr,
   input  logic [BURSTLEN_WIDTH-1:0] m1_burst_len,
   input  logic                      m1_rd,
   input  logic                      m1_wr,
   input  logic [DATA_WIDTH-1:0]     m1_wr_data,
   output logic [DATA_WIDTH-1:0]     m1_rd_data,
   output logic                      m1_rd_valid,
   output logic                      m1_waitrequest,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [BURSTLEN_WIDTH-1:0] mem_burst_len,
   output logic [DATA_WIDTH-1:0]     mem_wr_data,
   output logic                      mem_rd,
   output logic                      mem_wr,
   input  logic [DATA_WIDTH-1:0]     mem_rd_data,
   input  logic                      mem_rd_valid,
   input  logic                      mem_waitrequest
);

   typedef enum logic [1:0] {IDLE, GRANT, RD_DATA} state_t;

   localparam logic [BURSTLEN_WIDTH-1:0] ONE = 1;

   state_t                    state_q, state_d;
   logic                      grant_q, grant_d;
   logic                      last_q, last_d;
   logic [BURSTLEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic [BURSTLEN_WIDTH-1:0] len_q, len_d;

   logic                      g_rd, g_wr;
   logic [BURSTLEN_WIDTH-1:0] g_len;
   logic                      in_grant, in_rd_data;
   logic                      rd_acc, wr_acc, first_beat;
   logic                      req0, req1, winner;

   assign g_rd       = grant_q ? m1_rd : m0_rd;
   assign g_wr       = grant_q ? m1_wr : m0_wr;
   assign g_len      = grant_q ? m1_burst_len : m0_burst_len;
   assign in_grant   = (state_q == GRANT);
   assign in_rd_data = (state_q == RD_DATA);

   // Address/data always follow grant_q; only the strobes are gated by state.
   assign mem_addr      = grant_q ? m1_addr : m0_addr;
   assign mem_burst_len = g_len;
   assign mem_wr_data   = grant_q ? m1_wr_data : m0_wr_data;
   assign mem_wr        = in_grant & g_wr;
   assign mem_rd        = in_grant & g_rd & ~g_wr;

   assign m0_waitrequest = (in_grant & ~grant_q) ? mem_waitrequest : 1'b1;
   assign m1_waitrequest = (in_grant &  grant_q) ? mem_waitrequest : 1'b1;

   assign m0_rd_data  = mem_rd_data;
   assign m1_rd_data  = mem_rd_data;
   assign m0_rd_valid = in_rd_data & ~grant_q & mem_rd_valid;
   assign m1_rd_valid = in_rd_data &  grant_q & mem_rd_valid;

   assign rd_acc     = mem_rd & ~mem_waitrequest;
   assign wr_acc     = mem_wr & ~mem_waitrequest;
   assign first_beat = (beat_cnt_q == '0);

   assign req0   = m0_rd | m0_wr;
   assign req1   = m1_rd | m1_wr;
   assign winner = (req0 & req1) ? ~last_q : req1;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      beat_cnt_d = beat_cnt_q;
      len_d      = len_q;
      unique case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               grant_d = winner;
               last_d  = winner;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (wr_acc) begin
               if (first_beat) len_d = g_len;
               // First beat compares against the live length, later ones the latched copy.
               if (first_beat ? (beat_cnt_q == g_len) : (beat_cnt_q == len_q)) begin
                  state_d    = IDLE;
                  beat_cnt_d = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + ONE;
               end
            end else if (rd_acc) begin
               len_d      = g_len;
               beat_cnt_d = '0;
               state_d    = RD_DATA;
            end else if (!g_rd && !g_wr && first_beat) begin
               state_d = IDLE;
            end
         end
         RD_DATA: begin
            if (mem_rd_valid) begin
               if (beat_cnt_q == len_q) begin
                  state_d    = IDLE;
                  beat_cnt_d = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + ONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= 1'b0;
         last_q     <= 1'b1;
         beat_cnt_q <= '0;
         len_q      <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         beat_cnt_q <= beat_cnt_d;
         len_q      <= len_d;
      end
   end

   // A requester raising rd and wr together is a protocol violation.
   rd_wr_exclusive: assert property (@(posedge clock) disable iff (reset)
      !(in_grant && g_rd && g_wr));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: requester and memory models with a
// reference memory image; randomized traffic plus directed timing scenarios.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [BW-1:0] m0_burst_len, m1_burst_len;
   logic          m0_rd, m1_rd, m0_wr, m1_wr;
   logic [DW-1:0] m0_wr_data, m1_wr_data;
   logic [DW-1:0] m0_rd_data, m1_rd_data;
   logic          m0_rd_valid, m1_rd_valid;
   logic          m0_waitrequest, m1_waitrequest;
   logic [AW-1:0] mem_addr;
   logic [BW-1:0] mem_burst_len;
   logic [DW-1:0] mem_wr_data;
   logic          mem_rd, mem_wr;
   logic [DW-1:0] mem_rd_data;
   logic          mem_rd_valid;
   logic          mem_waitrequest;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BW)) dut (
      .clock(clock), .reset(reset),
      .m0_addr(m0_addr), .m0_burst_len(m0_burst_len), .m0_rd(m0_rd),
      .m0_wr(m0_wr), .m0_wr_data(m0_wr_data), .m0_rd_data(m0_rd_data),
      .m0_rd_valid(m0_rd_valid), .m0_waitrequest(m0_waitrequest),
      .m1_addr(m1_addr), .m1_burst_len(m1_burst_len), .m1_rd(m1_rd),
      .m1_wr(m1_wr), .m1_wr_data(m1_wr_data), .m1_rd_data(m1_rd_data),
      .m1_rd_valid(m1_rd_valid), .m1_waitrequest(m1_waitrequest),
      .mem_addr(mem_addr), .mem_burst_len(mem_burst_len),
      .mem_wr_data(mem_wr_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
      .mem_waitrequest(mem_waitrequest)
   );

   always #5 clock = ~clock;

   // memory model storage and the image requesters expect to see
   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];

   // requester jobs
   bit          job_act  [2];
   bit          job_wr   [2];
   logic [31:0] job_addr [2];
   int          job_len  [2];
   int          job_beat [2];
   bit          job_racc [2];
   logic [31:0] job_wd   [2][8];
   int          reissue  [2];
   int          acc_cyc  [2];
   int          end_cyc  [2];

   // memory slave state
   bit rd_busy;
   int rd_owner, rd_word, rd_len, rd_beat;
   int mw_beat, mw_word, mw_len;
   int          wlog_word [$];
   logic [31:0] wlog_data [$];
   int          glog [$];

   int wmode, gapmode;
   bit stray, end_prev;
   int cyc, proto_err, data_err, last_served;
   int n_cmp, n_err;

   task automatic start_job(input int p, input bit wr, input logic [31:0] a, input int len);
      job_act[p]  = 1'b1;
      job_wr[p]   = wr;
      job_addr[p] = a;
      job_len[p]  = len;
      job_beat[p] = 0;
      job_racc[p] = 1'b0;
      for (int k = 0; k < 8; k++) job_wd[p][k] = $urandom;
   endtask

   task automatic finish_job(input int p);
      job_act[p] = 1'b0;
      end_cyc[p] = cyc;
      if (reissue[p] > 0) begin
         reissue[p]--;
         start_job(p, 1'b0, 32'($urandom_range(0, 500)) << 2, int'($urandom_range(0, 7)));
      end
   endtask

   task automatic clear_model();
      for (int p = 0; p < 2; p++) begin
         job_act[p] = 1'b0;
         job_racc[p] = 1'b0;
         reissue[p] = 0;
      end
      rd_busy = 1'b0;
      mw_beat = 0;
      stray = 1'b0;
      end_prev = 1'b0;
      last_served = 1;
   endtask

   // One clock: drive at +1, sample and update models at +4.
   task automatic tick();
      int p;
      bit a0, a1, macc, ended;
      logic [31:0] exp;
      @(posedge clock);
      #1;
      cyc++;
      m0_addr      = job_addr[0];
      m0_burst_len = BW'(job_len[0]);
      m0_rd        = job_act[0] && !job_wr[0] && !job_racc[0];
      m0_wr        = job_act[0] && job_wr[0];
      m0_wr_data   = job_wd[0][job_beat[0] & 7];
      m1_addr      = job_addr[1];
      m1_burst_len = BW'(job_len[1]);
      m1_rd        = job_act[1] && !job_wr[1] && !job_racc[1];
      m1_wr        = job_act[1] && job_wr[1];
      m1_wr_data   = job_wd[1][job_beat[1] & 7];
      case (wmode)
         0: mem_waitrequest = 1'b0;
         1: mem_waitrequest = cyc[0];
         default: mem_waitrequest = ($urandom_range(0, 2) == 0);
      endcase
      if (rd_busy && (gapmode == 0 || $urandom_range(0, 3) != 0)) begin
         mem_rd_valid = 1'b1;
         mem_rd_data  = mem[(rd_word + rd_beat) & 1023];
      end else begin
         mem_rd_valid = stray;
         mem_rd_data  = $urandom;
      end
      #3;
      ended = 1'b0;
      if (m0_rd_valid !== (mem_rd_valid && rd_busy && rd_owner == 0)) proto_err++;
      if (m1_rd_valid !== (mem_rd_valid && rd_busy && rd_owner == 1)) proto_err++;
      if (mem_rd_valid && rd_busy) begin
         p = rd_owner;
         exp = ref_mem[((job_addr[p] >> 2) + job_beat[p]) & 1023];
         if ((p == 0 ? m0_rd_data : m1_rd_data) !== exp) data_err++;
         rd_beat++;
         if (rd_beat > rd_len) rd_busy = 1'b0;
         job_beat[p]++;
         if (job_beat[p] > job_len[p]) begin
            finish_job(p);
            ended = 1'b1;
         end
      end
      if (mem_rd && mem_wr) proto_err++;
      if (!m0_waitrequest && !m1_waitrequest) proto_err++;
      if (end_prev && (mem_rd || mem_wr)) proto_err++;
      a0 = (m0_rd || m0_wr) && !m0_waitrequest;
      a1 = (m1_rd || m1_wr) && !m1_waitrequest;
      macc = (mem_rd || mem_wr) && !mem_waitrequest;
      if ((a0 || a1) !== macc) proto_err++;
      if (mem_rd && !mem_waitrequest) begin
         rd_busy  = 1'b1;
         rd_owner = a1 ? 1 : 0;
         rd_word  = int'(mem_addr >> 2);
         rd_len   = int'(mem_burst_len);
         rd_beat  = 0;
      end
      if (mem_wr && !mem_waitrequest) begin
         if (mw_beat == 0) begin
            mw_word = int'(mem_addr >> 2);
            mw_len  = int'(mem_burst_len);
         end
         mem[(mw_word + mw_beat) & 1023] = mem_wr_data;
         wlog_word.push_back(mw_word + mw_beat);
         wlog_data.push_back(mem_wr_data);
         mw_beat++;
         if (mw_beat > mw_len) mw_beat = 0;
      end
      for (int q = 0; q < 2; q++) begin
         if ((q == 0 && a0) || (q == 1 && a1)) begin
            if (mem_addr !== job_addr[q] || mem_burst_len !== BW'(job_len[q])
                || mem_wr !== job_wr[q]) proto_err++;
            if (job_wr[q] && mem_wr_data !== job_wd[q][job_beat[q] & 7]) proto_err++;
            if (!job_wr[q] || job_beat[q] == 0) begin
               glog.push_back(q);
               acc_cyc[q] = cyc;
               last_served = q;
            end
            if (job_wr[q]) begin
               ref_mem[((job_addr[q] >> 2) + job_beat[q]) & 1023] = job_wd[q][job_beat[q] & 7];
               job_beat[q]++;
               if (job_beat[q] > job_len[q]) begin
                  finish_job(q);
                  ended = 1'b1;
               end
            end else begin
               job_racc[q] = 1'b1;
            end
         end
      end
      end_prev = ended;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      clear_model();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      clear_model();
      start_job(0, 1'b0, 32'h40, 5);
      start_job(1, 1'b1, 32'h80, 2);
      stray = 1'b1;
      tick();
      n_cmp++;
      if ({mem_rd, mem_wr, m0_waitrequest, m1_waitrequest, m0_rd_valid, m1_rd_valid} !== 6'b001100) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b want 001100",
            {mem_rd, mem_wr, m0_waitrequest, m1_waitrequest, m0_rd_valid, m1_rd_valid});
      end
      n_cmp++;
      if ({mem_addr, mem_burst_len, mem_wr_data} !== {32'h40, 3'd5, job_wd[0][0]}) begin
         n_err++;
         $display("FAIL reset_fwd: got %h/%0d/%h want 40/5/%h",
            mem_addr, mem_burst_len, mem_wr_data, job_wd[0][0]);
      end
      clear_model();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_single_read();
      int m1v;
      m1v = 0;
      wmode = 0;
      gapmode = 0;
      proto_err = 0;
      data_err = 0;
      start_job(0, 1'b0, 32'h100, 7);
      tick();
      n_cmp++;
      if (mem_rd !== 1'b0) begin
         n_err++;
         $display("FAIL single_arb_cycle: mem_rd %b want 0", mem_rd);
      end
      tick();
      n_cmp++;
      if ({mem_rd, mem_addr, mem_burst_len} !== {1'b1, 32'h100, 3'd7}) begin
         n_err++;
         $display("FAIL single_fwd: got %b/%h/%0d want 1/100/7", mem_rd, mem_addr, mem_burst_len);
      end
      for (int i = 0; i < 40 && job_act[0]; i++) begin
         tick();
         if (m1_rd_valid) m1v++;
      end
      n_cmp++;
      if (job_act[0] || job_beat[0] != 8) begin
         n_err++;
         $display("FAIL single_beats: got %0d want 8", job_beat[0]);
      end
      n_cmp++;
      if (m1v !== 0 || data_err !== 0 || proto_err !== 0) begin
         n_err++;
         $display("FAIL single_data: m1v %0d data_err %0d proto_err %0d want 0",
            m1v, data_err, proto_err);
      end
   endtask

   task automatic test_simultaneous();
      int w1err;
      w1err = 0;
      reset_dut();
      wmode = 0;
      gapmode = 0;
      proto_err = 0;
      data_err = 0;
      glog.delete();
      start_job(0, 1'b0, 32'h200, 7);
      start_job(1, 1'b0, 32'h400, 7);
      for (int i = 0; i < 60 && (job_act[0] || job_act[1]); i++) begin
         tick();
         if (job_act[0] && m1_waitrequest !== 1'b1) w1err++;
      end
      n_cmp++;
      if (job_act[0] || job_act[1]) begin
         n_err++;
         $display("FAIL sim_timeout: beats %0d/%0d want 8/8", job_beat[0], job_beat[1]);
      end
      n_cmp++;
      if (glog.size() != 2 || glog[0] != 0 || glog[1] != 1) begin
         n_err++;
         $display("FAIL sim_order: got %0d grants first %0d want 2 grants 0,1",
            glog.size(), glog.size() > 0 ? glog[0] : -1);
      end
      n_cmp++;
      if (acc_cyc[1] - end_cyc[0] != 2) begin
         n_err++;
         $display("FAIL sim_gap: got %0d want 2", acc_cyc[1] - end_cyc[0]);
      end
      n_cmp++;
      if (w1err !== 0 || data_err !== 0 || proto_err !== 0) begin
         n_err++;
         $display("FAIL sim_proto: w1err %0d data_err %0d proto_err %0d want 0",
            w1err, data_err, proto_err);
      end
   endtask

   task automatic test_write_stall();
      int bad;
      bad = 0;
      wmode = 1;
      gapmode = 0;
      proto_err = 0;
      data_err = 0;
      glog.delete();
      wlog_word.delete();
      wlog_data.delete();
      start_job(1, 1'b1, 32'hC00, 7);
      tick();
      tick();
      start_job(0, 1'b0, 32'hC00, 7);
      for (int i = 0; i < 100 && (job_act[0] || job_act[1]); i++) tick();
      n_cmp++;
      if (job_act[0] || job_act[1]) begin
         n_err++;
         $display("FAIL wr_timeout: beats %0d/%0d want 8/8", job_beat[0], job_beat[1]);
      end
      for (int k = 0; k < 8 && k < wlog_word.size(); k++)
         if (wlog_word[k] != 768 + k || wlog_data[k] !== job_wd[1][k]) bad++;
      n_cmp++;
      if (wlog_word.size() != 8 || bad != 0) begin
         n_err++;
         $display("FAIL wr_beats: got %0d beats %0d bad want 8 beats 0 bad", wlog_word.size(), bad);
      end
      n_cmp++;
      if (glog.size() != 2 || glog[0] != 1 || glog[1] != 0) begin
         n_err++;
         $display("FAIL wr_next_grant: got %0d grants want 1 then 0", glog.size());
      end
      n_cmp++;
      if (acc_cyc[0] < end_cyc[1] + 2) begin
         n_err++;
         $display("FAIL wr_turnaround: gap %0d want >=2", acc_cyc[0] - end_cyc[1]);
      end
      n_cmp++;
      if (data_err !== 0 || proto_err !== 0) begin
         n_err++;
         $display("FAIL wr_proto: data_err %0d proto_err %0d want 0", data_err, proto_err);
      end
   endtask

   task automatic test_fairness();
      int first, alt_bad, n0;
      alt_bad = 0;
      n0 = 0;
      wmode = 2;
      gapmode = 1;
      proto_err = 0;
      data_err = 0;
      glog.delete();
      first = 1 - last_served;
      start_job(0, 1'b0, 32'($urandom_range(0, 500)) << 2, int'($urandom_range(0, 7)));
      start_job(1, 1'b0, 32'($urandom_range(0, 500)) << 2, int'($urandom_range(0, 7)));
      reissue[0] = 9;
      reissue[1] = 9;
      for (int i = 0; i < 3000 && (job_act[0] || job_act[1]); i++) tick();
      n_cmp++;
      if (job_act[0] || job_act[1]) begin
         n_err++;
         $display("FAIL fair_timeout: grants %0d want 20", glog.size());
      end
      foreach (glog[i]) begin
         if (glog[i] != ((first + i) % 2)) alt_bad++;
         if (glog[i] == 0) n0++;
      end
      n_cmp++;
      if (glog.size() != 20 || alt_bad != 0) begin
         n_err++;
         $display("FAIL fair_order: grants %0d out-of-turn %0d want 20/0", glog.size(), alt_bad);
      end
      n_cmp++;
      if (n0 != 10) begin
         n_err++;
         $display("FAIL fair_count: port0 grants %0d want 10", n0);
      end
      n_cmp++;
      if (data_err !== 0 || proto_err !== 0) begin
         n_err++;
         $display("FAIL fair_proto: data_err %0d proto_err %0d want 0", data_err, proto_err);
      end
   endtask

   task automatic test_stray_reset();
      int sv;
      sv = 0;
      wmode = 0;
      gapmode = 0;
      proto_err = 0;
      data_err = 0;
      stray = 1'b1;
      repeat (3) begin
         tick();
         if (m0_rd_valid || m1_rd_valid) sv++;
      end
      stray = 1'b0;
      n_cmp++;
      if (sv !== 0) begin
         n_err++;
         $display("FAIL stray_valid: got %0d want 0", sv);
      end
      start_job(0, 1'b0, 32'h300, 7);
      for (int i = 0; i < 40 && job_beat[0] < 3; i++) tick();
      n_cmp++;
      if (job_beat[0] != 3) begin
         n_err++;
         $display("FAIL rst_pre_beats: got %0d want 3", job_beat[0]);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({mem_rd, mem_wr, m0_waitrequest, m1_waitrequest, m0_rd_valid, m1_rd_valid,
           mem_addr} !== {6'b001100, 32'h300}) begin
         n_err++;
         $display("FAIL rst_mid_burst: got %b/%h want 001100/300",
            {mem_rd, mem_wr, m0_waitrequest, m1_waitrequest, m0_rd_valid, m1_rd_valid}, mem_addr);
      end
      clear_model();
      tick();
      n_cmp++;
      if ({mem_rd, mem_wr, m0_waitrequest, m1_waitrequest, m0_rd_valid, m1_rd_valid} !== 6'b001100) begin
         n_err++;
         $display("FAIL rst_held: got %b want 001100",
            {mem_rd, mem_wr, m0_waitrequest, m1_waitrequest, m0_rd_valid, m1_rd_valid});
      end
      reset = 1'b0;
      start_job(0, 1'b0, 32'h340, 7);
      for (int i = 0; i < 40 && job_act[0]; i++) tick();
      n_cmp++;
      if (job_act[0] || job_beat[0] != 8 || data_err !== 0 || proto_err !== 0) begin
         n_err++;
         $display("FAIL rst_fresh_read: beats %0d data_err %0d proto_err %0d want 8/0/0",
            job_beat[0], data_err, proto_err);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      cyc = 0;
      proto_err = 0;
      data_err = 0;
      wmode = 0;
      gapmode = 0;
      mem_rd_valid = 1'b0;
      mem_rd_data = '0;
      mem_waitrequest = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         mem[i] = 32'hC0DE_0000 ^ 32'(i);
         ref_mem[i] = 32'hC0DE_0000 ^ 32'(i);
      end
      for (int p = 0; p < 2; p++) begin
         job_addr[p] = '0;
         job_len[p] = 0;
         job_beat[p] = 0;
         job_wr[p] = 1'b0;
         acc_cyc[p] = 0;
         end_cyc[p] = 0;
         for (int k = 0; k < 8; k++) job_wd[p][k] = '0;
      end
      test_reset();
      test_single_read();
      test_simultaneous();
      test_write_stall();
      test_fairness();
      test_stray_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
